apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Round-robin arbiter and sequencer in front of the APB master's user-side command interface (Transfer, Wr_Rd, Address, write_data, read_data).
- Lets NUM_REQ independent requesters share the single APB master/slave subsystem.
- Latches one requester's command, holds the master's command inputs stable until completion or timeout, returns read data and error to that requester, and advances the priority pointer.
- Completion is fed back from the integration level as m_done/m_slverr, taken from PSELx & PENABLE & PREADY and PSLVERR.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, command address width
DATA_W, 32, data width
TIMEOUT, 16, max cycles in XFER before abort (>=2)

Ports:
PCLK  in  1  clock, rising edge
PRESET  in  1  asynchronous active-high reset
req  in  NUM_REQ  per-requester request, held until its ack
req_write  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
gnt  out  NUM_REQ  one-hot owner of current transaction
ack  out  NUM_REQ  one-cycle completion pulse to owner
rdata  out  DATA_W  read data, valid with ack
err  out  1  slave error or timeout, valid with ack
busy  out  1  state != IDLE
Transfer  out  1  to master: transfer request
Wr_Rd  out  1  to master: direction
Address  out  ADDR_W  to master: address
write_data  out  DATA_W  to master: write data
m_rdata  in  DATA_W  from master read_data
m_done  in  1  APB access phase completed this cycle
m_slverr  in  1  PSLVERR, qualified by m_done

Behaviour:
- All outputs registered. Reset values: gnt=0, ack=0, rdata=0, err=0, busy=0, Transfer=0, Wr_Rd=0, Address=0, write_data=0, state=IDLE, timeout counter=0, last_ptr=NUM_REQ-1 (requester 0 has top priority after reset).
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - If any req bit is set, select the first set bit searching from last_ptr+1 upward, wrapping modulo NUM_REQ.
  - Latch req_write/addr/wdata of the winner into Wr_Rd/Address/write_data.
  - Set gnt one-hot and Transfer=1, clear counter, go to XFER.
  - With no req, stay in IDLE.
- XFER:
  - Transfer, Wr_Rd, Address, write_data and gnt are held constant.
  - Counter increments each cycle.
  - If m_done=1: capture rdata=m_rdata on a read (rdata unchanged on a write), set err=m_slverr, Transfer=0, go to RESP.
  - Else if counter reaches TIMEOUT-1: Transfer=0, err=1, rdata unchanged, go to RESP.
  - m_done takes precedence over timeout when both occur in the same cycle.
- RESP:
  - ack[owner]=1 for exactly this cycle; rdata/err valid.
  - Set last_ptr=owner; clear gnt on exit; go to IDLE.
  - err/rdata hold until the next RESP.
- Latency: req sampled in IDLE at cycle n -> gnt/Transfer high at n+1. m_done at cycle m -> ack at m+1. Minimum one IDLE cycle between transactions, so a requester holding req high after ack is re-arbitrated as a new transaction.
- Requester changing its req fields or dropping req while owned: ignored; the latched command completes and ack still pulses.
- m_done outside XFER: ignored.
- Fairness: a requester waits at most NUM_REQ-1 transactions.
- PRESET mid-transaction: everything returns to reset values immediately (asynchronous), no ack is generated, and the pointer resets.

Test Plan:
- Single read: req=0b0100, addr2=5'h0A; bench slave m_done 2 cycles after Transfer with m_rdata=32'hDEADBEEF -> gnt=0b0100 one cycle after req, Address=5'h0A, Wr_Rd=0, then ack=0b0100 one cycle after m_done, rdata=32'hDEADBEEF, err=0.
- Round-robin: req=0b1111 held continuously, each transaction completed after 1 cycle -> grant order 0,1,2,3,0 with exactly one IDLE cycle between transactions.
- Write with error: requester 1 write, addr=5'h03, wdata=32'h12345678; m_done with m_slverr=1 -> write_data=32'h12345678 held throughout XFER, ack[1] with err=1, rdata unchanged.
- Timeout: TIMEOUT=16, m_done never asserted -> Transfer drops after 16 XFER cycles, ack pulses with err=1; m_done and timeout in the same cycle -> err=m_slverr.
- Reset mid-XFER: assert PRESET during XFER -> all outputs 0 without a clock edge, no ack; after release with req=0b1010, requester 1 is granted first.
- Field change during XFER: requester changes its addr after gnt -> Address keeps the latched value until ack.

Source files
------------

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_req_arbiter : round-robin command arbiter in front of one APB master
// Revision 1.0
// ----------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        err,
    output logic                        busy,
    output logic                        Transfer,
    output logic                        Wr_Rd,
    output logic [ADDR_W-1:0]           Address,
    output logic [DATA_W-1:0]           write_data,
    input  logic [DATA_W-1:0]           m_rdata,
    input  logic                        m_done,
    input  logic                        m_slverr
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [PTR_W-1:0]   PTR_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [1:0]         state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
    logic [PTR_W-1:0]   owner_q,    owner_d;
    logic [NUM_REQ-1:0] gnt_q,      gnt_d;
    logic [NUM_REQ-1:0] ack_q,      ack_d;
    logic [DATA_W-1:0]  rdata_q,    rdata_d;
    logic               err_q,      err_d;
    logic               busy_q,     busy_d;
    logic               transfer_q, transfer_d;
    logic               wr_rd_q,    wr_rd_d;
    logic [ADDR_W-1:0]  address_q,  address_d;
    logic [DATA_W-1:0]  wdata_q,    wdata_d;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
            assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Search starts just past the last owner so the previous winner ranks lowest.
    logic             win_valid;
    logic [PTR_W-1:0] win_idx;

    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] cand;
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx  = (int'(last_ptr_q) + i) % NUM_REQ;
            cand = PTR_W'(idx);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_ptr_d = last_ptr_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        transfer_d = transfer_q;
        wr_rd_d    = wr_rd_q;
        address_d  = address_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    owner_d    = win_idx;
                    gnt_d      = ONE_HOT0 << win_idx;
                    transfer_d = 1'b1;
                    wr_rd_d    = req_write[win_idx];
                    address_d  = addr_arr[win_idx];
                    wdata_d    = wdata_arr[win_idx];
                    cnt_d      = '0;
                    state_d    = S_XFER;
                end
            end
            S_XFER: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the final cycle wins over the timeout abort.
                if (m_done) begin
                    if (!wr_rd_q) begin
                        rdata_d = m_rdata;
                    end
                    err_d      = m_slverr;
                    transfer_d = 1'b0;
                    ack_d      = gnt_q;
                    state_d    = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d      = 1'b1;
                    transfer_d = 1'b0;
                    ack_d      = gnt_q;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                last_ptr_d = owner_q;
                gnt_d      = '0;
                state_d    = S_IDLE;
            end
            default: begin
                gnt_d      = '0;
                transfer_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_ptr_q <= PTR_RST;
            owner_q    <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            transfer_q <= 1'b0;
            wr_rd_q    <= 1'b0;
            address_q  <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_ptr_q <= last_ptr_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            transfer_q <= transfer_d;
            wr_rd_q    <= wr_rd_d;
            address_q  <= address_d;
            wdata_q    <= wdata_d;
        end
    end

    assign gnt        = gnt_q;
    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign Transfer   = transfer_q;
    assign Wr_Rd      = wr_rd_q;
    assign Address    = address_q;
    assign write_data = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_apb_req_arbiter : directed scoreboard bench for apb_req_arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_apb_req_arbiter;

    logic        PCLK;
    logic        PRESET;
    logic [3:0]  req;
    logic [3:0]  req_write;
    logic [19:0] req_addr;
    logic [127:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    logic        Transfer;
    logic        Wr_Rd;
    logic [4:0]  Address;
    logic [31:0] write_data;
    logic [31:0] m_rdata;
    logic        m_done;
    logic        m_slverr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  owner;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    apb_req_arbiter #(
        .NUM_REQ(4), .ADDR_W(5), .DATA_W(32), .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
        .Transfer(Transfer), .Wr_Rd(Wr_Rd), .Address(Address), .write_data(write_data),
        .m_rdata(m_rdata), .m_done(m_done), .m_slverr(m_slverr)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge PCLK);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] o, input logic [31:0] d, input logic e);
        exp_t x;
        x.owner = o;
        x.rdata = d;
        x.err   = e;
        sb.push_back(x);
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s.sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, ".ack"},   ack,   x.owner);
            chk({tag, ".rdata"}, rdata, x.rdata);
            chk({tag, ".err"},   err,   x.err);
        end
    endtask

    initial begin
        int n;
        PRESET    = 1'b1;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_rdata   = '0;
        m_done    = 1'b0;
        m_slverr  = 1'b0;
        #12;
        chk("rst.gnt", gnt, 0);
        chk("rst.busy", busy, 0);
        chk("rst.xfer", Transfer, 0);
        chk("rst.rdata", rdata, 0);
        step();
        PRESET = 1'b0;

        // Single read from requester 2
        req_addr[2*5 +: 5] = 5'h0A;
        req = 4'b0100;
        step();
        chk("rd.gnt", gnt, 4'b0100);
        chk("rd.xfer", Transfer, 1);
        chk("rd.addr", Address, 5'h0A);
        chk("rd.wrrd", Wr_Rd, 0);
        chk("rd.busy", busy, 1);
        step();
        m_done  = 1'b1;
        m_rdata = 32'hDEADBEEF;
        push(4'b0100, 32'hDEADBEEF, 1'b0);
        step();
        m_done = 1'b0;
        pop_check("rd");
        chk("rd.xfer_off", Transfer, 0);
        req = '0;
        step();
        chk("rd.ack_once", ack, 0);
        chk("rd.idle", busy, 0);
        chk("rd.gnt_clr", gnt, 0);

        // Round-robin from fresh reset: 0,1,2,3,0
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr%0d.gnt", k), gnt, 4'b0001 << (k % 4));
            m_done  = 1'b1;
            m_rdata = 32'hA000_0000 + k;
            push(4'b0001 << (k % 4), 32'hA000_0000 + k, 1'b0);
            step();
            m_done = 1'b0;
            pop_check($sformatf("rr%0d", k));
            step();
            chk($sformatf("rr%0d.idle", k), busy, 0);
            if (k == 4) req = '0;
            step();
        end
        chk("rr.no_regrant", busy, 0);

        // Write with slave error from requester 1
        req_write[1]           = 1'b1;
        req_addr[1*5 +: 5]     = 5'h03;
        req_wdata[1*32 +: 32]  = 32'h12345678;
        req = 4'b0010;
        step();
        chk("wr.gnt", gnt, 4'b0010);
        chk("wr.wrrd", Wr_Rd, 1);
        chk("wr.addr", Address, 5'h03);
        req_wdata[1*32 +: 32] = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("wr.wdata%0d", k), write_data, 32'h12345678);
            step();
        end
        m_done   = 1'b1;
        m_slverr = 1'b1;
        m_rdata  = 32'hFFFFFFFF;
        push(4'b0010, 32'hA000_0004, 1'b1);
        step();
        m_done   = 1'b0;
        m_slverr = 1'b0;
        pop_check("wr");
        req = '0;
        req_write = '0;
        step();

        // Timeout: requester 0 read, slave never responds
        req = 4'b0001;
        step();
        n = 0;
        while (Transfer === 1'b1 && n < 40) begin
            n++;
            step();
        end
        chk("to.cycles", n, 16);
        push(4'b0001, 32'hA000_0004, 1'b1);
        pop_check("to");

        // Completion in the same cycle the timeout would fire
        step();
        chk("to2.idle", busy, 0);
        step();
        chk("to2.gnt", gnt, 4'b0001);
        for (int k = 0; k < 15; k++) step();
        chk("to2.xfer_last", Transfer, 1);
        m_done   = 1'b1;
        m_slverr = 1'b0;
        m_rdata  = 32'h55AA55AA;
        push(4'b0001, 32'h55AA55AA, 1'b0);
        step();
        m_done = 1'b0;
        pop_check("to2");
        req = '0;
        step();

        // m_done while idle must be ignored
        m_done = 1'b1;
        step();
        m_done = 1'b0;
        chk("idle_done.ack", ack, 0);
        chk("idle_done.busy", busy, 0);

        // Asynchronous reset in the middle of a transfer
        req = 4'b1000;
        req_addr[3*5 +: 5] = 5'h1C;
        step();
        chk("ar.gnt_pre", gnt, 4'b1000);
        #1 PRESET = 1'b1;
        #1;
        chk("ar.gnt", gnt, 0);
        chk("ar.xfer", Transfer, 0);
        chk("ar.busy", busy, 0);
        chk("ar.addr", Address, 0);
        chk("ar.rdata", rdata, 0);
        chk("ar.err", err, 0);
        step();
        step();
        chk("ar.noack", ack, 0);
        req = 4'b1010;
        req_addr[1*5 +: 5] = 5'h11;
        PRESET = 1'b0;
        step();
        chk("ar.first", gnt, 4'b0010);
        chk("fc.addr0", Address, 5'h11);

        // Field change by the owner during the transfer
        req_addr[1*5 +: 5] = 5'h1F;
        step();
        chk("fc.addr1", Address, 5'h11);
        req[1] = 1'b0;
        step();
        chk("fc.addr2", Address, 5'h11);
        m_done  = 1'b1;
        m_rdata = 32'h0BADF00D;
        push(4'b0010, 32'h0BADF00D, 1'b0);
        step();
        m_done = 1'b0;
        pop_check("fc");
        chk("fc.addr_ack", Address, 5'h11);
        req = '0;
        step();

        chk("sb.empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
